// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path.
// - Header codes: the first byte of every UART packet, naming its payload type.
// - FSM state encoding for the arbiter. These are plain 2-bit localparams rather
//   than an enum so that the Yosys flow can read them.
// - idx_width(): width of a source index. It is never less than 1.
package uart_pkg;

  localparam logic [7:0] PARROT          = 8'd0;
  localparam logic [7:0] ETH_FRAME_IN    = 8'd1;
  localparam logic [7:0] ETH_FRAME_OUT   = 8'd2;
  localparam logic [7:0] REMAINING_LAYER = 8'd3;
  localparam logic [7:0] INSTRUCTION     = 8'd4;
  localparam logic [7:0] BRAIN_STATUS    = 8'd5;
  localparam logic [7:0] PAYLOAD_COMING  = 8'd6;
  localparam logic [7:0] INFO            = 8'd7;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeader = 2'd1;
  localparam logic [1:0] StData   = 2'd2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Stream bundle between the source streams, the arbiter and the UART transmitter.
// Modports:
// - master: the arbiter's view. It consumes the sources and drives the UART side.
// - slave:  the environment's view. It drives the sources and the UART ready.
// Signals:
// - src_tdata:  flattened source data. Source i is at [DATA_WIDTH*i +: DATA_WIDTH].
// - src_tvalid, src_tready, src_tlast: per-source handshake.
// - uart_out_tdata, uart_out_tvalid, uart_out_tready, uart_out_tlast: byte stream
//   to the UART.
interface uart_tx_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SRC    = 3
);
  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
  logic [NUM_SRC-1:0]            src_tvalid;
  logic [NUM_SRC-1:0]            src_tready;
  logic [NUM_SRC-1:0]            src_tlast;
  logic [DATA_WIDTH-1:0]         uart_out_tdata;
  logic                          uart_out_tvalid;
  logic                          uart_out_tready;
  logic                          uart_out_tlast;

  modport master (
    input  src_tdata, src_tvalid, src_tlast, uart_out_tready,
    output src_tready, uart_out_tdata, uart_out_tvalid, uart_out_tlast
  );

  modport slave (
    output src_tdata, src_tvalid, src_tlast, uart_out_tready,
    input  src_tready, uart_out_tdata, uart_out_tvalid, uart_out_tlast
  );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
// The search starts at (last + 1) mod NUM_SRC. The first requester found wins.
// Ports:
// - req:     per-source request.
// - last:    index of the previous winner.
// - gnt:     one-hot winner. All zeros when nothing is requested.
// - gnt_idx: index of the winner. 0 when nothing is requested.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]                   req,
  input  logic [idx_width(NUM_SRC)-1:0]        last,
  output logic [NUM_SRC-1:0]                   gnt,
  output logic [idx_width(NUM_SRC)-1:0]        gnt_idx
);
  localparam int unsigned IdxW = idx_width(NUM_SRC);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = (int'(last) + i) % NUM_SRC;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges NUM_SRC byte streams onto one UART transmitter.
// Each transfer is a header byte, which names the source via HDR_CODES, followed by
// source data.
//
// Optional feature, selected by the macro UART_TX_BURST_EN:
// - Defined: one header precedes a whole burst. The burst ends on the granted source's
//   tlast, and uart_out_tlast mirrors that tlast.
// - Undefined: every data byte gets its own header. src_tlast is ignored, and
//   uart_out_tlast marks each header+byte pair.
//
// Ports:
// - clk, rst_n: clock and asynchronous active-low reset.
// - bus: the uart_tx_arbiter_if master modport. It carries the source streams and
//   the UART stream.
// - grant: one-hot current owner. 0 in IDLE.
// - busy: high whenever the FSM is outside IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           NUM_SRC    = 3,
  parameter logic [NUM_SRC*8-1:0]  HDR_CODES  = {BRAIN_STATUS, ETH_FRAME_OUT, REMAINING_LAYER}
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.master   bus,
  output logic [NUM_SRC-1:0]  grant,
  output logic                busy
);
  localparam int unsigned IdxW = idx_width(NUM_SRC);

  logic [1:0]         state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [IdxW-1:0]    idx_q;
  logic [IdxW-1:0]    last_q;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic [7:0]         hdr_byte;
  logic               out_hs;
  logic               burst_done;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req     (bus.src_tvalid),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign hdr_byte = HDR_CODES[8*idx_q +: 8];
  assign out_hs   = bus.uart_out_tvalid && bus.uart_out_tready;

`ifdef UART_TX_BURST_EN
  assign burst_done = bus.src_tlast[idx_q];
`else
  logic unused_tlast;
  assign unused_tlast = ^bus.src_tlast;
  assign burst_done   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      // Park on the last source so that source 0 is favoured first after reset.
      last_q  <= IdxW'(NUM_SRC - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (|bus.src_tvalid) begin
            grant_q <= arb_gnt;
            idx_q   <= arb_idx;
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (out_hs) state_q <= StData;
        end
        StData: begin
          // Never abandon a granted source: leave only on a completing handshake.
          if (out_hs && burst_done) begin
            last_q  <= idx_q;
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

  // Output mux. The header byte comes from registered state only, so it stays stable
  // under back-pressure. In the data phase the granted source passes straight through.
  always_comb begin
    bus.uart_out_tvalid = 1'b0;
    bus.uart_out_tdata  = '0;
    bus.uart_out_tlast  = 1'b0;
    bus.src_tready      = '0;
    case (state_q)
      StHeader: begin
        bus.uart_out_tvalid = 1'b1;
        bus.uart_out_tdata  = DATA_WIDTH'(hdr_byte);
      end
      StData: begin
        bus.uart_out_tvalid   = bus.src_tvalid[idx_q];
        bus.uart_out_tdata    = bus.src_tdata[DATA_WIDTH*idx_q +: DATA_WIDTH];
        bus.src_tready[idx_q] = bus.uart_out_tready;
        bus.uart_out_tlast    = burst_done;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: byte width of every stream.
REQ-002 The block SHALL have parameter NUM_SRC, default 3: number of source streams.
REQ-003 The block SHALL have parameter HDR_CODES, default {8'd5, 8'd2, 8'd3}, NUM_SRC*8 bits: header byte per source, where source i uses bits [8i+7:8i]. Source 0 is REMAINING_LAYER = 3, source 1 is ETH_FRAME_OUT = 2, source 2 is BRAIN_STATUS = 5.
REQ-004 The block SHALL have one clock and asynchronous active-low reset, with ports as follows:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- src_tdata  in  NUM_SRC*DATA_WIDTH  flattened source data, source i at [DATA_WIDTH*i +: DATA_WIDTH]
- src_tvalid  in  NUM_SRC  per-source valid
- src_tready  out  NUM_SRC  per-source ready
- src_tlast  in  NUM_SRC  per-source last
- uart_out_tdata  out  DATA_WIDTH  byte to UART transmitter
- uart_out_tvalid  out  1  output valid
- uart_out_tready  in  1  output ready
- uart_out_tlast  out  1  end of UART packet
- grant  out  NUM_SRC  one-hot current owner; 0 in IDLE
- busy  out  1  high when not in IDLE

Function
REQ-005 The block SHALL implement FSM states IDLE, HEADER and DATA.
REQ-006 IDLE: if any src_tvalid is set, the block SHALL pick a winner round-robin, starting at (last_grant+1) mod NUM_SRC. It SHALL register the winner into grant and enter HEADER on the next edge. Arbitration latency is 1 cycle.
REQ-007 IDLE SHALL drive uart_out_tvalid=0 and src_tready=0.
REQ-008 HEADER SHALL drive uart_out_tvalid=1, uart_out_tdata=HDR_CODES byte of the granted source, and uart_out_tlast=0. On uart_out_tvalid&&uart_out_tready it SHALL go to DATA.
REQ-009 grant SHALL remain constant from HEADER entry until return to IDLE, whatever the src_tvalid changes.
REQ-010 DATA SHALL pass through combinationally:
- uart_out_tdata = granted src_tdata
- uart_out_tvalid = granted src_tvalid
- granted src_tready = uart_out_tready
- all other src_tready = 0
REQ-011 DATA, on a handshake: the block SHALL update last_grant to the granted index and return to IDLE, subject to REQ-017.
REQ-012 Once a header has been sent, the block SHALL wait indefinitely in DATA for the granted source's valid. It SHALL NOT abandon the grant.
REQ-013 When several sources are valid at once, each SHALL be served within NUM_SRC grants. No source SHALL be starved.
REQ-014 uart_out_tvalid, once high in HEADER, SHALL NOT deassert before the handshake, and uart_out_tdata SHALL stay stable meanwhile.
REQ-015 An IDLE-to-IDLE byte cycle SHALL take at least 3 clocks (IDLE, HEADER, DATA) with uart_out_tready held at 1.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously force:
- state = IDLE
- grant = 0
- last_grant = NUM_SRC-1, so source 0 wins first after reset
- uart_out_tvalid = 0, uart_out_tdata = 0, uart_out_tlast = 0
- src_tready = 0, busy = 0
Reset asserted during HEADER or DATA SHALL abort the transfer. A partial byte SHALL NOT be consumed after reset release.

Configuration
REQ-017 With macro UART_TX_BURST_EN defined:
- in DATA the block SHALL stay in DATA after each handshake until one completes with granted src_tlast=1, then go to IDLE
- one header SHALL precede the whole burst
- uart_out_tlast SHALL equal granted src_tlast in DATA
REQ-018 With UART_TX_BURST_EN undefined:
- every data byte SHALL be preceded by its own header
- src_tlast SHALL be ignored
- uart_out_tlast SHALL be 1 in DATA, marking each header+byte pair

Structure
REQ-019 Header code constants (PARROT=0, ETH_FRAME_IN=1, ETH_FRAME_OUT=2, REMAINING_LAYER=3, INSTRUCTION=4, BRAIN_STATUS=5, PAYLOAD_COMING=6, INFO=7) and the state encoding SHALL live in shared package uart_pkg. The state encoding SHALL be 2-bit localparams, not an enum, for Yosys.
REQ-020 The round-robin picker SHALL be sub-module rr_arbiter. It is combinational: inputs req[NUM_SRC] and last[$clog2(NUM_SRC)]; outputs one-hot gnt and gnt_idx.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then src1 sends 0xA5 with ready=1 -> UART sees 0x02 then 0xA5; grant=3'b010 for 2 cycles, then busy=0.
- src0, src1 and src2 all valid continuously with bytes 0x10/0x20/0x30 -> UART order 03 10, 02 20, 05 30, 03 10 (round-robin from source 0).
- uart_out_tready=0 for 5 cycles during HEADER -> tdata held at header code, tvalid held at 1, no src_tready asserted.
- Granted source deasserts tvalid for 4 cycles in DATA -> uart_out_tvalid=0, grant unchanged, transfer completes after valid returns.
- rst_n pulsed low mid-DATA -> all outputs 0 immediately; after release, the next grant goes to source 0.
- UART_TX_BURST_EN defined, src2 sends 0x01,0x02,0x03 with tlast on 0x03 -> UART sees 05 01 02 03, with uart_out_tlast only on 0x03.
